// File: rtl/audio_feeder_pkg.sv
// ============================================================================
//  audio_feeder_pkg
//  Shared sample width and playback FSM state encoding for the audio feeder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package audio_feeder_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/audio_fifo.sv
// ============================================================================
//  audio_fifo
//  Single-clock sample FIFO with occupancy output; no write-to-read bypass.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module audio_fifo
    import audio_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_en_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_w;
    logic             pop_w;

    // Guards here keep the FIFO safe even if a caller ignores full/empty.
    assign push_w    = wr_en_i && (level_q != FULL_LVL);
    assign pop_w     = rd_en_i && (level_q != '0);
    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    always_ff @(posedge CLK) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_w, pop_w})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/audio_feeder.sv
// ============================================================================
//  audio_feeder
//  Buffers PCM audio and emits a per-clock linearly interpolated modulation word.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module audio_feeder
    import audio_feeder_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int LOG2_DIV    = 11,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic signed [SAMPLE_W-1:0]  s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        enable,
    input  logic                        clr_underrun,
    output logic signed [SAMPLE_W-1:0]  mod_out,
    output logic                        tick,
    output logic                        underrun,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int ACC_W = SAMPLE_W + LOG2_DIV + 1;
    localparam logic [LW-1:0]       FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0]       PRIME_LVL = LW'(PRIME_LEVEL);
    localparam logic [LOG2_DIV-1:0] PH_LAST   = '1;

    state_e                  state_q, state_d;
    logic [SAMPLE_W-1:0]     cur_q, cur_d;
    logic [SAMPLE_W-1:0]     next_q, next_d;
    logic [SAMPLE_W:0]       step_q, step_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [LOG2_DIV-1:0]     phase_q, phase_d;
    logic                    tick_q, tick_d;
    logic                    underrun_q, underrun_d;
    logic [SAMPLE_W-1:0]     mod_q;
    logic [SAMPLE_W-1:0]     head_w;
    logic [LW-1:0]           level_w;
    logic                    pop_w;
    logic                    push_w;

    assign s_ready  = (level_w < FULL_LVL);
    assign push_w   = s_valid && s_ready;
    assign level    = level_w;
    assign mod_out  = mod_q;
    assign tick     = tick_q;
    assign underrun = underrun_q;

    audio_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .wr_data_i (s_data),
        .wr_en_i   (push_w),
        .rd_en_i   (pop_w),
        .rd_data_o (head_w),
        .level_o   (level_w)
    );

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        next_d     = next_q;
        step_d     = step_q;
        acc_d      = acc_q;
        phase_d    = phase_q;
        tick_d     = 1'b0;
        pop_w      = 1'b0;
        underrun_d = clr_underrun ? 1'b0 : underrun_q;
        case (state_q)
            ST_IDLE: begin
                acc_d   = '0;
                phase_d = '0;
                if (enable) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                acc_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (level_w >= PRIME_LVL) begin
                    // First segment ramps from silence up to the first sample.
                    pop_w   = 1'b1;
                    next_d  = head_w;
                    cur_d   = '0;
                    step_d  = {head_w[SAMPLE_W-1], head_w};
                    phase_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                end else if (phase_q == PH_LAST) begin
                    // Reload instead of adding so every sample is hit exactly.
                    cur_d   = next_q;
                    acc_d   = {cur_d[SAMPLE_W-1], cur_d, {LOG2_DIV{1'b0}}};
                    tick_d  = 1'b1;
                    phase_d = '0;
                    if (level_w != '0) begin
                        pop_w  = 1'b1;
                        next_d = head_w;
                        step_d = {head_w[SAMPLE_W-1], head_w} - {next_q[SAMPLE_W-1], next_q};
                    end else begin
                        step_d     = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    acc_d   = acc_q + {{LOG2_DIV{step_q[SAMPLE_W]}}, step_q};
                    phase_d = phase_q + LOG2_DIV'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            next_q     <= '0;
            step_q     <= '0;
            acc_q      <= '0;
            phase_q    <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            mod_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            next_q     <= next_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            mod_q      <= acc_q[LOG2_DIV+SAMPLE_W-1:LOG2_DIV];
        end
    end

endmodule

`default_nettype wire
